// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if
//   Handshake and status bundle for the single-clock flagged FIFO.
//   master : producer/consumer side. It drives w_valid, w_data, r_ready,
//            flush and err_clr, and observes everything else.
//   slave  : FIFO side. It drives w_ready, r_valid, r_data, count,
//            almost_full, almost_empty, overflow and underflow.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_ready;
  logic                  r_ready;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  flush;
  logic                  err_clr;
  logic [CW-1:0]         count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_valid, w_data, r_ready, flush, err_clr,
    input  w_ready, r_valid, r_data, count, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  w_valid, w_data, r_ready, flush, err_clr,
    output w_ready, r_valid, r_data, count, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//   Single-clock first-word-fall-through FIFO with occupancy count,
//   almost-full/almost-empty thresholds, synchronous flush and sticky
//   overflow/underflow error flags.
// Ports:
//   clk          : single clock, rising edge.
//   rst          : asynchronous active-high reset.
//   bus (slave)  : w_valid/w_data/w_ready  write handshake
//                  r_ready/r_valid/r_data  read handshake (r_data is 0 when empty)
//                  flush                   synchronous clear of contents
//                  err_clr                 synchronous clear of error flags
//                  count                   occupancy 0..DEPTH
//                  almost_full/almost_empty threshold flags
//                  overflow/underflow      sticky error flags
module sync_fifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_flags_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  logic full;
  logic empty;
  logic wr_en;
  logic rd_en;
  logic ov_set;
  logic un_set;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // Flush overrides both handshakes in the same cycle.
  assign wr_en  = bus.w_valid && !full  && !bus.flush;
  assign rd_en  = bus.r_ready && !empty && !bus.flush;
  // A write dropped by flush is not an overflow.
  assign ov_set = bus.w_valid && full && !bus.flush;
  assign un_set = bus.r_ready && empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= bus.w_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new violation beats err_clr in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ov_set)           overflow  <= 1'b1;
      else if (bus.err_clr) overflow  <= 1'b0;
      if (un_set)           underflow <= 1'b1;
      else if (bus.err_clr) underflow <= 1'b0;
    end
  end

  assign bus.w_ready      = !full;
  assign bus.r_valid      = !empty;
  assign bus.r_data       = empty ? '0 : mem[rptr[AW-1:0]];
  assign bus.count        = count;
  assign bus.almost_full  = (count >= AF_T);
  assign bus.almost_empty = (count <= AE_T);
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int AFULL  = DEPTH - 2;
  localparam int AEMPTY = 2;

  logic clk;
  logic rst;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of words plus two sticky bits.
  logic [DW-1:0] q[$];
  logic          m_ov;
  logic          m_un;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("w_ready",      32'(bus.w_ready),      32'(n != DEPTH));
    check("r_valid",      32'(bus.r_valid),      32'(n != 0));
    check("r_data",       32'(bus.r_data),       (n != 0) ? 32'(q[0]) : 32'd0);
    check("count",        32'(bus.count),        32'(n));
    check("almost_full",  32'(bus.almost_full),  32'(n >= AFULL));
    check("almost_empty", 32'(bus.almost_empty), 32'(n <= AEMPTY));
    check("overflow",     32'(bus.overflow),     32'(m_ov));
    check("underflow",    32'(bus.underflow),    32'(m_un));
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, let the rising edge act,
  // then compare against the model just after the next falling edge.
  task automatic cyc(input logic wv, input logic [DW-1:0] wd, input logic rr,
                     input logic fl, input logic ec);
    bit full_m, empty_m, ov_set, un_set;
    @(negedge clk);
    bus.w_valid = wv;
    bus.w_data  = wd;
    bus.r_ready = rr;
    bus.flush   = fl;
    bus.err_clr = ec;
    full_m  = (q.size() == DEPTH);
    empty_m = (q.size() == 0);
    ov_set  = wv && full_m && !fl;
    un_set  = rr && empty_m;
    if (fl) begin
      q.delete();
    end else begin
      if (rr && !empty_m) void'(q.pop_front());
      if (wv && !full_m)  q.push_back(wd);
    end
    if (ov_set)  m_ov = 1'b1;
    else if (ec) m_ov = 1'b0;
    if (un_set)  m_un = 1'b1;
    else if (ec) m_un = 1'b0;
    @(negedge clk);
    #1 check_all();
    bus.w_valid = 1'b0;
    bus.r_ready = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
    bus.r_ready = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_all();

    // Idle after reset.
    cyc(0, 8'h00, 0, 0, 0);

    // Fill 0x01..0x10, then overflow attempts with 0xAA.
    for (int i = 1; i <= DEPTH; i++) cyc(1, 8'(i), 0, 0, 0);
    repeat (3) cyc(1, 8'hAA, 0, 0, 0);

    // Drain in order, then underflow attempts.
    for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1, 0, 0);
    repeat (2) cyc(0, 8'h00, 1, 0, 0);

    // Clear flags, bring count to 5, stream 40 cycles across the wrap.
    cyc(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 8'($urandom), 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, 8'($urandom), 1, 0, 0);

    // Fill to full, then simultaneous write and read.
    while (q.size() < DEPTH) cyc(1, 8'($urandom), 0, 0, 0);
    cyc(1, 8'h77, 1, 0, 0);
    // err_clr without violation clears; err_clr with violation keeps it.
    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'h66, 0, 0, 0);
    cyc(1, 8'h55, 0, 0, 1);

    // Flush at count 7 with a coincident write; then write 0x5C.
    cyc(0, 8'h00, 0, 0, 1);
    while (q.size() > 7) cyc(0, 8'h00, 1, 0, 0);
    cyc(1, 8'h99, 0, 1, 0);
    cyc(1, 8'h5C, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);

    // Randomized traffic with alternating write/read bias.
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 80; i++) begin
        int wb;
        wb = (seg % 2 == 0) ? 75 : 30;
        cyc($urandom_range(0, 99) < wb,
            8'($urandom),
            $urandom_range(0, 99) < (100 - wb),
            $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 5);
      end
    end

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 6; i++) cyc(1, 8'($urandom), 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
    #1 check_all();
    cyc(1, 8'h3E, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
